// File: rtl/pulse_peak_finder.sv
// Threshold-triggered pulse peak finder: captures peak, peak timestamp and width per pulse.
// Optional pile-up flagging is enabled with `define PEAK_PILEUP_EN.
module pulse_peak_finder #(
    parameter int unsigned DATA_W    = 16,
    parameter int          THRESHOLD = 100,
    parameter int unsigned HOLDOFF   = 4,
    parameter int unsigned TS_W      = 32,
    parameter int unsigned WIDTH_W   = 8,
    parameter int unsigned DROP_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_peak,
    output logic [TS_W-1:0]          out_ts,
    output logic [WIDTH_W-1:0]       out_width,
    output logic                     out_pileup,
    output logic [DROP_W-1:0]        drop_count
);

    localparam int unsigned HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HO_W-1:0] HO_INIT = HO_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic signed [DATA_W-1:0] THR = DATA_W'(THRESHOLD);

    typedef enum logic [1:0] {StIdle, StTrack, StHoldoff} state_e;

    state_e                     state_q, state_d;
    logic [TS_W-1:0]            ts_q;
    logic signed [DATA_W-1:0]   peak_q, peak_d;
    logic [TS_W-1:0]            peak_ts_q, peak_ts_d;
    logic [WIDTH_W-1:0]         width_q, width_d;
    logic [HO_W-1:0]            hcnt_q, hcnt_d;
    logic                       above, emit, load, valid_d;
    logic [DROP_W-1:0]          drop_d;

    assign above = in_data > THR;

    always_comb begin
        state_d   = state_q;
        peak_d    = peak_q;
        peak_ts_d = peak_ts_q;
        width_d   = width_q;
        hcnt_d    = hcnt_q;
        emit      = 1'b0;
        case (state_q)
            StIdle: begin
                if (above) begin
                    state_d   = StTrack;
                    peak_d    = in_data;
                    peak_ts_d = ts_q;
                    width_d   = WIDTH_W'(1);
                end
            end
            StTrack: begin
                if (above) begin
                    if (width_q != '1) width_d = width_q + WIDTH_W'(1);
                    // Strict compare keeps the earliest timestamp on ties.
                    if (in_data > peak_q) begin
                        peak_d    = in_data;
                        peak_ts_d = ts_q;
                    end
                end else begin
                    emit = 1'b1;
                    if (HOLDOFF == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StHoldoff;
                        hcnt_d  = HO_INIT;
                    end
                end
            end
            StHoldoff: begin
                if (hcnt_q == '0) state_d = StIdle;
                else              hcnt_d  = hcnt_q - HO_W'(1);
            end
            default: state_d = StIdle;
        endcase
    end

    // Output register: a pending event blocks new ones unless it is taken on the same edge.
    always_comb begin
        valid_d = out_valid;
        drop_d  = drop_count;
        load    = 1'b0;
        if (emit) begin
            if (!out_valid || out_ready) begin
                load    = 1'b1;
                valid_d = 1'b1;
            end else if (drop_count != '1) begin
                drop_d = drop_count + DROP_W'(1);
            end
        end else if (out_valid && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ts_q       <= '0;
            peak_q     <= '0;
            peak_ts_q  <= '0;
            width_q    <= '0;
            hcnt_q     <= '0;
            out_valid  <= 1'b0;
            out_peak   <= '0;
            out_ts     <= '0;
            out_width  <= '0;
            drop_count <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_q + TS_W'(1);
            peak_q     <= peak_d;
            peak_ts_q  <= peak_ts_d;
            width_q    <= width_d;
            hcnt_q     <= hcnt_d;
            out_valid  <= valid_d;
            drop_count <= drop_d;
            if (load) begin
                out_peak  <= peak_q;
                out_ts    <= peak_ts_q;
                out_width <= width_q;
            end
        end
    end

`ifdef PEAK_PILEUP_EN
    logic sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (state_q == StHoldoff && above) sticky_d = 1'b1;
        if (emit) sticky_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_q   <= 1'b0;
            out_pileup <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            if (load) out_pileup <= sticky_q;
        end
    end
`else
    assign out_pileup = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_peak_finder.sv
// Self-checking bench for pulse_peak_finder: directed scenarios then random pulses,
// compared against a queue-based pulse model.
module tb_pulse_peak_finder;

    localparam int DATA_W    = 16;
    localparam int THRESHOLD = 100;
    localparam int HOLDOFF   = 4;
    localparam int TS_W      = 32;
    localparam int WIDTH_W   = 8;
    localparam int DROP_W    = 16;
    localparam int WIDTH_MAX = (1 << WIDTH_W) - 1;
    localparam int DROP_MAX  = (1 << DROP_W) - 1;

    logic                     clk;
    logic                     reset;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_peak;
    logic [TS_W-1:0]          out_ts;
    logic [WIDTH_W-1:0]       out_width;
    logic                     out_pileup;
    logic [DROP_W-1:0]        drop_count;

    pulse_peak_finder #(
        .DATA_W   (DATA_W),
        .THRESHOLD(THRESHOLD),
        .HOLDOFF  (HOLDOFF),
        .TS_W     (TS_W),
        .WIDTH_W  (WIDTH_W),
        .DROP_W   (DROP_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_peak  (out_peak),
        .out_ts    (out_ts),
        .out_width (out_width),
        .out_pileup(out_pileup),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pulse samples collected in queues, evaluated when the pulse ends.
    int  cyc;
    bit  in_pulse;
    int  hold_end;
    bit  sticky;
    int  q_d[$];
    int  q_t[$];
    bit  m_valid;
    int  m_peak, m_ts, m_width, m_drop;
    bit  m_pile;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; in_pulse = 0; hold_end = -1; sticky = 0;
        q_d.delete(); q_t.delete();
        m_valid = 0; m_peak = 0; m_ts = 0; m_width = 0; m_drop = 0; m_pile = 0;
    endtask

    task automatic model_edge(input int d, input bit rdy);
        bit above;
        bit emit;
        int best, e_peak, e_ts, e_w;
        above = d > THRESHOLD;
        emit = 0;
        e_peak = 0; e_ts = 0; e_w = 0;
        if (in_pulse) begin
            if (above) begin
                q_d.push_back(d); q_t.push_back(cyc);
            end else begin
                best = 0;
                for (int i = 1; i < q_d.size(); i++) if (q_d[i] > q_d[best]) best = i;
                e_peak = q_d[best];
                e_ts   = q_t[best];
                e_w    = (q_d.size() > WIDTH_MAX) ? WIDTH_MAX : q_d.size();
                emit = 1;
                in_pulse = 0;
                hold_end = cyc + HOLDOFF;
                q_d.delete(); q_t.delete();
            end
        end else if (cyc > hold_end) begin
            if (above) begin
                in_pulse = 1;
                q_d.push_back(d); q_t.push_back(cyc);
            end
        end else if (above) begin
            sticky = 1;
        end
        if (emit) begin
            if (!m_valid || rdy) begin
                m_valid = 1; m_peak = e_peak; m_ts = e_ts; m_width = e_w;
`ifdef PEAK_PILEUP_EN
                m_pile = sticky;
`else
                m_pile = 0;
`endif
            end else if (m_drop < DROP_MAX) begin
                m_drop++;
            end
            sticky = 0;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        cyc++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, out_valid, m_valid);
        chk({tag, ".drop"}, drop_count, m_drop);
        if (m_valid) begin
            chk({tag, ".peak"}, out_peak, m_peak);
            chk({tag, ".ts"}, out_ts, m_ts);
            chk({tag, ".width"}, out_width, m_width);
            chk({tag, ".pileup"}, out_pileup, m_pile);
        end
    endtask

    task automatic step(input int d, input bit rdy, input string tag);
        in_data = d[DATA_W-1:0];
        out_ready = rdy;
        @(posedge clk);
        model_edge(d, rdy);
        #1;
        check_all(tag);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1;
        model_reset();
    endtask

    int t0;
    int d;
    bit hi;
    int seq1[7] = '{0, 0, 50, 150, 300, 250, 90};

    initial begin
        clk = 0; reset = 0; in_data = '0; out_ready = 1;
        model_reset();
        #12;
        chk("rst.valid", out_valid, 0);
        chk("rst.peak", out_peak, 0);
        chk("rst.ts", out_ts, 0);
        chk("rst.width", out_width, 0);
        chk("rst.pileup", out_pileup, 0);
        chk("rst.drop", drop_count, 0);
        release_reset();

        // Basic pulse from reset release.
        foreach (seq1[i]) step(seq1[i], 1, "basic");
        chk("basic.valid_k", out_valid, 1);
        chk("basic.peak_k", out_peak, 300);
        chk("basic.ts_k", out_ts, 4);
        chk("basic.width_k", out_width, 3);
        chk("basic.drop_k", drop_count, 0);
        repeat (6) step(0, 1, "basic_tail");

        // Tie keeps the earliest timestamp.
        t0 = cyc;
        step(0, 1, "tie"); step(200, 1, "tie"); step(200, 1, "tie"); step(50, 1, "tie");
        chk("tie.peak_k", out_peak, 200);
        chk("tie.ts_k", out_ts, t0 + 1);
        chk("tie.width_k", out_width, 2);
        repeat (6) step(0, 1, "tie_tail");

        // Back-to-back with consumer stalled: second event dropped.
        step(200, 0, "b2b"); step(200, 0, "b2b"); step(50, 0, "b2b");
        repeat (6) step(0, 0, "b2b");
        step(300, 0, "b2b"); step(50, 0, "b2b");
        chk("b2b.drop_k", drop_count, 1);
        chk("b2b.peak_k", out_peak, 200);
        step(0, 1, "b2b_accept");
        chk("b2b.valid_k", out_valid, 0);
        repeat (6) step(0, 1, "b2b_tail");

        // Holdoff suppresses retrigger; pile-up flagged when enabled.
        step(300, 1, "hold"); step(90, 1, "hold");
        repeat (HOLDOFF) step(500, 1, "hold");
        step(500, 1, "hold"); step(50, 1, "hold");
        chk("hold.width_k", out_width, 1);
        repeat (6) step(0, 1, "hold_tail");

        // Reset mid-pulse discards the pulse and restarts ts.
        step(300, 1, "midrst"); step(300, 1, "midrst");
        #2 reset = 0;
        model_reset();
        #1;
        chk("midrst.valid", out_valid, 0);
        chk("midrst.drop", drop_count, 0);
        chk("midrst.peak", out_peak, 0);
        release_reset();
        step(0, 1, "midrst"); step(0, 1, "midrst");
        step(150, 1, "midrst"); step(50, 1, "midrst");
        chk("midrst.ts_k", out_ts, 2);
        repeat (6) step(0, 1, "midrst_tail");

        // Width saturation.
        repeat (300) step(200, 1, "sat");
        step(50, 1, "sat");
        chk("sat.width_k", out_width, WIDTH_MAX);
        repeat (6) step(0, 1, "sat_tail");

        // Random pulses with random back-pressure.
        hi = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) hi = !hi;
            if (hi) d = THRESHOLD + 1 + (($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 400)));
            else    d = -200 + int'($urandom_range(0, 300));
            step(d, $urandom_range(0, 3) != 0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_peak_finder.md
Name: pulse_peak_finder

Overview:
- Downstream consumer of the shaping filter's output stream. It takes one signed filtered sample per clock and detects pulses by threshold crossing.
- For each pulse it captures the peak amplitude, the peak timestamp and the width above threshold.
- Each result is presented as one event on a valid/ready interface to the readout/histogram logic.
- A holdoff after each pulse suppresses retriggering on the shaper's tail.

Parameters:
- DATA_W, SIZE_FILTER_DATA, width of the filtered input sample and the peak output (signed).
- THRESHOLD, 100, signed trigger level; a sample is "above" when strictly greater than THRESHOLD.
- HOLDOFF, 4, cycles spent in HOLDOFF after each event (0 allowed).
- TS_W, 32, width of the free-running timestamp counter.
- WIDTH_W, 8, width of the pulse-width field; saturates at all-ones.
- DROP_W, 16, width of the dropped-event counter; saturates at all-ones.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  in  DATA_W  signed filtered sample, new value every clock.
- out_valid  out  1  event available.
- out_ready  in  1  consumer accepts event when out_valid && out_ready at a rising edge.
- out_peak  out  DATA_W  signed peak amplitude of the event.
- out_ts  out  TS_W  timestamp of the peak sample.
- out_width  out  WIDTH_W  number of above-threshold samples in the pulse.
- out_pileup  out  1  pile-up flag (see Optional Feature).
- drop_count  out  DROP_W  events lost because the output register was occupied.

Behaviour:
- Reset, asynchronous while reset=0:
  - state=IDLE; ts, peak, width, holdoff counter, pile-up sticky and drop_count all 0.
  - All outputs 0, including out_valid.
  - Reset mid-pulse discards the pulse; no event is emitted.
- Timestamp:
  - The ts counter is 0 in the first cycle after reset release and increments every clock, wrapping modulo 2^TS_W.
  - The timestamp of a sample is the ts value in the cycle the sample is on in_data.
- State machine (evaluated on each rising edge using the current in_data):
  - IDLE: if in_data > THRESHOLD, go to TRACK with peak=in_data, peak_ts=ts, width=1. Otherwise stay.
  - TRACK: if in_data > THRESHOLD, width +1 (saturating). If in_data > peak (strictly), update peak and peak_ts, so ties keep the earliest timestamp.
  - TRACK exit: if in_data <= THRESHOLD, emit the event. Go to HOLDOFF with counter=HOLDOFF-1, or directly to IDLE if HOLDOFF=0.
  - HOLDOFF: decrement the counter; at 0 go to IDLE. in_data is ignored for triggering.
  - The first trigger after HOLDOFF can occur in the cycle IDLE is entered's next edge.
- Emit / output register:
  - An emit in cycle N yields out_valid=1 after edge N+1 with out_peak/out_ts/out_width latched.
  - Emit while out_valid=0: load the register.
  - Emit while out_valid=1 and out_ready=1 (same edge): the new event replaces the old one, out_valid stays 1, no drop.
  - Emit while out_valid=1 and out_ready=0: the new event is dropped, drop_count +1 (saturating), and the register is unchanged.
  - Handshake without emit: out_valid goes to 0.
  - Output fields are stable while out_valid=1 and out_ready=0.
- Arithmetic:
  - All comparisons are signed at DATA_W.
  - width and drop_count saturate; they never wrap.

Optional Feature:
- Macro PEAK_PILEUP_EN.
- Defined:
  - A sample with in_data > THRESHOLD while in HOLDOFF sets a sticky pile-up bit.
  - The next emitted event carries out_pileup=1, and the sticky bit clears on that emit.
  - A pulse still in TRACK when it is emitted also carries out_pileup=1 if the sticky bit was set before it started.
- Not defined: out_pileup is constant 0 and no sticky logic is synthesized.

Test Plan:
- Reset release, in_data samples 0,0,50,150,300,250,90 (ts 0..6), out_ready=1 -> one event: out_valid=1 after the edge following ts 6; peak=300, ts=4, width=3; drop_count=0.
- Tie: samples 0,200,200,50 -> peak=200, ts=1, width=2.
- Back-to-back with out_ready=0: two pulses separated by more than HOLDOFF -> first event held stable, second dropped, drop_count=1; raise out_ready -> first event accepted, out_valid=0.
- Holdoff: pulse ending at ts 10 (falls to 90), then 500 at ts 11..13 with HOLDOFF=4 -> no trigger until IDLE is re-entered. With PEAK_PILEUP_EN, the next event has out_pileup=1.
- Reset asserted mid-TRACK (peak 300 captured) -> out_valid stays 0, state IDLE, ts restarts at 0 after release.
- Width saturation: 300 above-threshold samples with WIDTH_W=8 -> out_width=255.
